// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types for the two-master SDRAM request arbiter:
//   - arb_state_t  : arbiter FSM states (IDLE / ISSUE / WAIT)
//   - NUM_MASTERS  : number of requesting clients (fixed at 2)
//   - sdram_req_t  : captured request {rd, wr, addr, wdata}. Fields are sized
//                    for the widest supported configuration; the arbiter
//                    zero-extends into them and truncates back out.
//   - owner_onehot : index-to-one-hot helper for routing completions.
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int NUM_MASTERS    = 2;
    localparam int MAX_ADDR_WIDTH = 32;
    localparam int MAX_DATA_WIDTH = 32;
    localparam int MAX_WORD_LEN   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                      rd;
        logic [MAX_WORD_LEN-1:0]   wr;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0] wdata;
    } sdram_req_t;

    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input logic owner);
        logic [NUM_MASTERS-1:0] oh;
        if (owner) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// -----------------------------------------------------------------------------
// sdram_rr_pick
// Combinational two-way round-robin picker.
// Ports:
//   req        in  2  per-master request
//   last_grant in  1  index of the master granted most recently
//   grant      out 2  one-hot selected master (0 when nobody requests)
//   valid      out 1  some master is selected
// A lone requester always wins; on a tie the master that did not win last
// time is selected, so continuous contention strictly alternates.
// -----------------------------------------------------------------------------
module sdram_rr_pick
    import sdram_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_grant,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   valid
);

    // Select the winner from the request pattern and the previous owner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        valid = |req;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Two-master round-robin arbiter in front of a single-outstanding SDRAM
// controller. One request is captured in IDLE, presented to the controller in
// ISSUE until s_rdy, then the arbiter waits in WAIT for the read/write
// completion and routes it back to the owning master.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   m_rd/m_wr/m_addr/m_wdata     per-master requests (m_wr = byte enables)
//   m_rdy                        per-master accept (IDLE only, combinational)
//   m_rvalid/m_wvalid/m_rdata    completions routed to the owner
//   m_error                      per-master watchdog pulse
//   s_rd/s_wr/s_addr/s_wdata     controller command
//   s_rdy/s_rvalid/s_wvalid/s_rdata  controller handshake and read data
// Build option: define SDRAM_ARB_TIMEOUT_EN to enable a watchdog that
// abandons a transaction after TIMEOUT_CYCLES cycles in ISSUE/WAIT. Without
// it m_error is tied low and WAIT may last indefinitely.
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int WORD_LEN       = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS-1:0]          m_rd,
    input  logic [NUM_MASTERS*WORD_LEN-1:0] m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]          m_rdy,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    output logic [NUM_MASTERS-1:0]          m_wvalid,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic [NUM_MASTERS-1:0]          m_error,
    output logic                            s_rd,
    output logic [WORD_LEN-1:0]             s_wr,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    input  logic                            s_rdy,
    input  logic                            s_rvalid,
    input  logic                            s_wvalid,
    input  logic [DATA_WIDTH-1:0]           s_rdata
);

    // Configuration sanity checks at elaboration.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_dw
        $error("sdram_arbiter: DATA_WIDTH must be 8, 16 or 32");
    end
    if (ADDR_WIDTH > MAX_ADDR_WIDTH || ADDR_WIDTH < 1) begin : g_bad_aw
        $error("sdram_arbiter: ADDR_WIDTH out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("sdram_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t             state_r;
    arb_state_t             state_s;
    logic                   last_grant_r;
    logic                   owner_r;
    sdram_req_t             req_r;

    logic [NUM_MASTERS-1:0] req_s;
    logic [NUM_MASTERS-1:0] grant_s;
    logic                   pick_valid_s;
    logic                   accept_s;
    logic                   sel_s;
    sdram_req_t             sel_req_s;
    logic                   rdone_s;
    logic                   wdone_s;
    logic                   tmo_hit_s;

    // A master requests when it asks to read or presents any byte enable.
    always_comb begin
        req_s[0] = m_rd[0] | (|m_wr[WORD_LEN-1:0]);
        req_s[1] = m_rd[1] | (|m_wr[2*WORD_LEN-1:WORD_LEN]);
    end

    sdram_rr_pick u_pick (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .valid      (pick_valid_s)
    );

    // Mux the selected master's request; read wins over write when both set.
    always_comb begin
        accept_s        = (state_r == ST_IDLE) && pick_valid_s && !rst;
        sel_s           = grant_s[1];
        sel_req_s       = '0;
        sel_req_s.rd    = sel_s ? m_rd[1] : m_rd[0];
        if (sel_req_s.rd) begin
            sel_req_s.wr = '0;
        end else if (sel_s) begin
            sel_req_s.wr = MAX_WORD_LEN'(m_wr[2*WORD_LEN-1:WORD_LEN]);
        end else begin
            sel_req_s.wr = MAX_WORD_LEN'(m_wr[WORD_LEN-1:0]);
        end
        sel_req_s.addr  = sel_s ? MAX_ADDR_WIDTH'(m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH])
                                : MAX_ADDR_WIDTH'(m_addr[ADDR_WIDTH-1:0]);
        sel_req_s.wdata = sel_s ? MAX_DATA_WIDTH'(m_wdata[2*DATA_WIDTH-1:DATA_WIDTH])
                                : MAX_DATA_WIDTH'(m_wdata[DATA_WIDTH-1:0]);
    end

    // Completions are only honoured in WAIT; anything else is stray.
    always_comb begin
        rdone_s = (state_r == ST_WAIT) && s_rvalid && !rst;
        wdone_s = (state_r == ST_WAIT) && s_wvalid && !rst;
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_r;

    // Watchdog counter: cleared on entry to ISSUE, counts while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (accept_s) begin
            tmo_cnt_r <= '0;
        end else if (state_r != ST_IDLE) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Limit reached; a completion in the same cycle takes priority.
    always_comb begin
        tmo_hit_s = (state_r != ST_IDLE) && !rst
                    && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES))
                    && !rdone_s && !wdone_s;
        m_error   = tmo_hit_s ? owner_onehot(owner_r) : 2'b00;
    end
`else
    assign tmo_hit_s = 1'b0;
    assign m_error   = 2'b00;
`endif

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (tmo_hit_s) begin
                    state_s = ST_IDLE;
                end else if (s_rdy) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (rdone_s || wdone_s || tmo_hit_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, round-robin history and captured request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            req_r        <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                req_r        <= sel_req_s;
                owner_r      <= sel_s;
                last_grant_r <= sel_s;
            end else begin
                req_r        <= req_r;
                owner_r      <= owner_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Master-side outputs: accept in IDLE, completions routed to the owner.
    always_comb begin
        m_rdy    = ((state_r == ST_IDLE) && !rst) ? grant_s : 2'b00;
        m_rvalid = rdone_s ? owner_onehot(owner_r) : 2'b00;
        m_wvalid = wdone_s ? owner_onehot(owner_r) : 2'b00;
        m_rdata  = rdone_s ? s_rdata : '0;
    end

    // Controller-side outputs: strobes only in ISSUE, address/data held.
    always_comb begin
        if ((state_r == ST_ISSUE) && !rst && !tmo_hit_s) begin
            s_rd = req_r.rd;
            s_wr = req_r.wr[WORD_LEN-1:0];
        end else begin
            s_rd = 1'b0;
            s_wr = '0;
        end
        s_addr  = req_r.addr[ADDR_WIDTH-1:0];
        s_wdata = req_r.wdata[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int WL = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      m_rd;
    logic [2*WL-1:0] m_wr;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [1:0]      m_rdy, m_rvalid, m_wvalid, m_error;
    logic [DW-1:0]   m_rdata;
    logic            s_rd;
    logic [WL-1:0]   s_wr;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_rdy, s_rvalid, s_wvalid;
    logic [DW-1:0]   s_rdata;

    int checks = 0;
    int errors = 0;

    sdram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_LEN(WL), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdy(m_rdy), .m_rvalid(m_rvalid), .m_wvalid(m_wvalid),
        .m_rdata(m_rdata), .m_error(m_error),
        .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdy(s_rdy), .s_rvalid(s_rvalid), .s_wvalid(s_wvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m_rd = 2'b00; m_wr = 4'b0000; s_rdy = 1'b0;
        s_rvalid = 1'b0; s_wvalid = 1'b0; s_rdata = 16'h0000;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        m_addr = {24'h000200, 24'h000100};
        m_wdata = {16'h2222, 16'h1111};
        rst = 1'b1;
        tick(); tick();
        m_rd = 2'b11;
        #1;
        checks++;
        if ({m_rdy, m_rvalid, m_wvalid, m_error, s_rd, s_wr} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {m_rdy, m_rvalid, m_wvalid, m_error, s_rd, s_wr});
        end
        checks++;
        if (s_addr !== 24'h0 || s_wdata !== 16'h0 || m_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got addr %h wdata %h rdata %h want 0", s_addr, s_wdata, m_rdata);
        end
        m_rd = 2'b00;
        rst = 1'b0;
        tick();
        checks++;
        if (m_rdy !== 2'b00 || s_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rdy %b s_rd %b want 00 0", m_rdy, s_rd);
        end
    endtask

    task automatic test_read;
        m_addr = {24'h000200, 24'h000100};
        m_rd = 2'b01;
        #1;
        checks++;
        if (m_rdy !== 2'b01) begin
            errors++; $display("FAIL read_rdy got %b want 01", m_rdy);
        end
        tick();
        m_rd = 2'b00;
        #1;
        checks++;
        if (s_rd !== 1'b1 || s_wr !== 2'b00 || s_addr !== 24'h000100 || m_rdy !== 2'b00) begin
            errors++;
            $display("FAIL read_issue got s_rd %b s_wr %b addr %h rdy %b want 1 00 000100 00", s_rd, s_wr, s_addr, m_rdy);
        end
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        #1;
        checks++;
        if (s_rd !== 1'b0 || s_addr !== 24'h000100) begin
            errors++; $display("FAIL read_wait got s_rd %b addr %h want 0 000100", s_rd, s_addr);
        end
        tick();
        s_rvalid = 1'b1; s_rdata = 16'hBEEF;
        #1;
        checks++;
        if (m_rvalid !== 2'b01 || m_rdata !== 16'hBEEF || m_wvalid !== 2'b00) begin
            errors++;
            $display("FAIL read_done got rvalid %b rdata %h wvalid %b want 01 beef 00", m_rvalid, m_rdata, m_wvalid);
        end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++;
        if (m_rvalid !== 2'b00 || m_rdata !== 16'h0000) begin
            errors++; $display("FAIL read_after got rvalid %b rdata %h want 00 0000", m_rvalid, m_rdata);
        end
    endtask

    task automatic test_fairness;
        logic [1:0]  exp_oh [3];
        logic [15:0] exp_d  [3];
        exp_oh[0] = 2'b01; exp_oh[1] = 2'b10; exp_oh[2] = 2'b01;
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h1111;
        do_reset();
        m_wdata = {16'h2222, 16'h1111};
        m_wr = 4'b1111;
        for (int g = 0; g < 3; g++) begin
            #1;
            checks++;
            if (m_rdy !== exp_oh[g]) begin
                errors++; $display("FAIL rr_grant%0d got %b want %b", g, m_rdy, exp_oh[g]);
            end
            tick();
            checks++;
            if (s_wr !== 2'b11 || s_rd !== 1'b0 || s_wdata !== exp_d[g]) begin
                errors++;
                $display("FAIL rr_issue%0d got s_wr %b s_rd %b wdata %h want 11 0 %h", g, s_wr, s_rd, s_wdata, exp_d[g]);
            end
            s_rdy = 1'b1;
            tick();
            s_rdy = 1'b0;
            s_wvalid = 1'b1;
            #1;
            checks++;
            if (m_wvalid !== exp_oh[g] || m_rvalid !== 2'b00) begin
                errors++; $display("FAIL rr_done%0d got wvalid %b rvalid %b want %b 00", g, m_wvalid, m_rvalid, exp_oh[g]);
            end
            checks++;
            if (m_rdy !== 2'b00) begin
                errors++; $display("FAIL rr_wait_rdy%0d got %b want 00", g, m_rdy);
            end
            tick();
            s_wvalid = 1'b0;
        end
        m_wr = 4'b0000;
    endtask

    task automatic test_rd_wr_both;
        m_addr = {24'h00ABCD, 24'h000100};
        m_rd = 2'b10;
        m_wr = 4'b1100;
        #1;
        checks++;
        if (m_rdy !== 2'b10) begin
            errors++; $display("FAIL both_rdy got %b want 10", m_rdy);
        end
        tick();
        m_rd = 2'b00; m_wr = 4'b0000;
        #1;
        checks++;
        if (s_rd !== 1'b1 || s_wr !== 2'b00 || s_addr !== 24'h00ABCD) begin
            errors++; $display("FAIL both_issue got s_rd %b s_wr %b addr %h want 1 00 00abcd", s_rd, s_wr, s_addr);
        end
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        s_rvalid = 1'b1; s_rdata = 16'h5A5A;
        #1;
        checks++;
        if (m_rvalid !== 2'b10 || m_wvalid !== 2'b00 || m_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL both_done got rvalid %b wvalid %b rdata %h want 10 00 5a5a", m_rvalid, m_wvalid, m_rdata);
        end
        tick();
        s_rvalid = 1'b0;
    endtask

    task automatic test_stall;
        m_addr = {24'h000200, 24'h000300};
        m_rd = 2'b01;
        tick();
        m_rd = 2'b10;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (s_rd !== 1'b1 || m_rdy !== 2'b00 || m_error !== 2'b00) begin
                errors++;
                $display("FAIL stall%0d got s_rd %b rdy %b err %b want 1 00 00", c, s_rd, m_rdy, m_error);
            end
            tick();
        end
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        #1;
        checks++;
        if (s_rd !== 1'b0 || s_addr !== 24'h000300) begin
            errors++; $display("FAIL stall_release got s_rd %b addr %h want 0 000300", s_rd, s_addr);
        end
        m_rd = 2'b00;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
    endtask

    task automatic test_back_to_back;
        m_wr = 4'b0011;
        m_wdata = {16'h2222, 16'h7777};
        tick();
        m_wr = 4'b0000;
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        s_wvalid = 1'b1;
        m_rd = 2'b01;
        #1;
        checks++;
        if (m_wvalid !== 2'b01 || m_rdy !== 2'b00) begin
            errors++; $display("FAIL b2b_done got wvalid %b rdy %b want 01 00", m_wvalid, m_rdy);
        end
        tick();
        s_wvalid = 1'b0;
        #1;
        checks++;
        if (m_rdy !== 2'b01 || m_wvalid !== 2'b00) begin
            errors++; $display("FAIL b2b_next got rdy %b wvalid %b want 01 00", m_rdy, m_wvalid);
        end
        tick();
        m_rd = 2'b00;
        #1;
        checks++;
        if (s_rd !== 1'b1) begin
            errors++; $display("FAIL b2b_issue got s_rd %b want 1", s_rd);
        end
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
    endtask

    task automatic test_reset_in_wait;
        m_addr = {24'h000222, 24'h000111};
        m_rd = 2'b01;
        tick();
        m_rd = 2'b00;
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_rvalid = 1'b1; s_rdata = 16'hDEAD;
        #1;
        checks++;
        if (m_rvalid !== 2'b00 || m_rdata !== 16'h0000 || s_rd !== 1'b0) begin
            errors++;
            $display("FAIL rstwait_stray got rvalid %b rdata %h s_rd %b want 00 0000 0", m_rvalid, m_rdata, s_rd);
        end
        tick();
        s_rvalid = 1'b0;
        m_rd = 2'b11;
        #1;
        checks++;
        if (m_rdy !== 2'b01) begin
            errors++; $display("FAIL rstwait_tie got %b want 01", m_rdy);
        end
        tick();
        m_rd = 2'b00;
        #1;
        checks++;
        if (s_rd !== 1'b1 || s_addr !== 24'h000111) begin
            errors++; $display("FAIL rstwait_issue got s_rd %b addr %h want 1 000111", s_rd, s_addr);
        end
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
    endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        m_rd = 2'b10;
        tick();
        m_rd = 2'b00;
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        #1;
        checks++;
        if (m_error !== 2'b10 || m_rvalid !== 2'b00) begin
            errors++; $display("FAIL timeout_err got %b rvalid %b want 10 00", m_error, m_rvalid);
        end
        tick();
        m_rd = 2'b01;
        #1;
        checks++;
        if (m_error !== 2'b00 || m_rdy !== 2'b01) begin
            errors++; $display("FAIL timeout_recover got err %b rdy %b want 00 01", m_error, m_rdy);
        end
        tick();
        m_rd = 2'b00;
        s_rdy = 1'b1;
        tick();
        s_rdy = 1'b0;
        s_rvalid = 1'b1;
        tick();
        s_rvalid = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_addr = '0;
        m_wdata = '0;
        idle_inputs();
        test_reset();
        test_read();
        test_fairness();
        test_rd_wr_both();
        test_stall();
        test_back_to_back();
        test_reset_in_wait();
`ifdef SDRAM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
